// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between the instruction-fetch port (IF) and the
// load/store port (DM). One command is issued per cycle. DM normally wins,
// but IF is guaranteed a slot after STARVE_MAX consecutive DM grants while it
// waits. Read ownership rides alongside the RAM latency in a tag pipeline so
// each read response is steered back to the port that issued it. A fetch
// flush kills every fetch response still in flight.

module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    input  logic            if_flush_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,

    input  logic            dm_req_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic            dm_wr_en_i,
    input  logic [XLEN-1:0] dm_wr_data_i,
    input  logic [3:0]      dm_byte_en_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [XLEN-1:0] dm_rdata_o,

    output logic            ram_en_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic [3:0]      ram_wr_byte_en_o,
    output logic [XLEN-1:0] ram_wr_data_o,
    input  logic [XLEN-1:0] ram_rd_data_i
);

    // Owner encoding carried in the tag pipeline.
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);
    localparam int         LAST         = RD_LAT - 1;

    logic [3:0]        starve_cnt_reg;
    logic [RD_LAT-1:0] tag_valid_reg;
    logic [RD_LAT-1:0] tag_owner_reg;

    logic if_cand;
    logic if_win;
    logic if_gnt;
    logic dm_gnt;
    logic rd_grant;
    logic rd_owner;
    logic last_valid;
    logic last_owner;

    // Grant decision: DM first unless IF has waited STARVE_MAX DM grants.
    // A flush removes IF from contention for the cycle; reset blocks both.
    always_comb begin
        if_cand  = if_req_i && !if_flush_i;
        if_win   = if_cand && (starve_cnt_reg == STARVE_LIMIT);
        dm_gnt   = !rst_i && dm_req_i && !if_win;
        if_gnt   = !rst_i && if_cand && !(dm_req_i && !if_win);
        rd_grant = if_gnt || (dm_gnt && !dm_wr_en_i);
        rd_owner = dm_gnt ? OWNER_DM : OWNER_IF;
    end

    assign if_gnt_o = if_gnt;
    assign dm_gnt_o = dm_gnt;

    // RAM command muxed straight from the winning requester; idle bus is all zero.
    always_comb begin
        ram_en_o         = if_gnt || dm_gnt;
        ram_addr_o       = '0;
        ram_wr_byte_en_o = 4'b0000;
        ram_wr_data_o    = '0;
        if (if_gnt) begin
            ram_addr_o = if_addr_i;
        end else if (dm_gnt) begin
            ram_addr_o = dm_addr_i;
            if (dm_wr_en_i) begin
                ram_wr_byte_en_o = dm_byte_en_i;
                ram_wr_data_o    = dm_wr_data_i;
            end
        end
    end

    // Count DM grants that overtook a waiting IF; any IF grant or IF
    // withdrawal (including a flush cycle) restarts the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_reg <= 4'd0;
        end else if (if_gnt || !if_cand) begin
            starve_cnt_reg <= 4'd0;
        end else if (dm_gnt && (starve_cnt_reg < STARVE_LIMIT)) begin
            starve_cnt_reg <= starve_cnt_reg + 4'd1;
        end
    end

    // Tag pipeline: one stage per cycle of RAM read latency. Writes enter as
    // bubbles. A flush drops IF-owned entries as they advance.
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                // Head stage captures the ownership of this cycle's read grant.
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        tag_valid_reg[gi] <= 1'b0;
                        tag_owner_reg[gi] <= OWNER_IF;
                    end else begin
                        tag_valid_reg[gi] <= rd_grant;
                        tag_owner_reg[gi] <= rd_owner;
                    end
                end
            end else begin : g_body
                // Later stages shift forward, squashing fetches on flush.
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        tag_valid_reg[gi] <= 1'b0;
                        tag_owner_reg[gi] <= OWNER_IF;
                    end else begin
                        tag_valid_reg[gi] <= tag_valid_reg[gi-1] &&
                            !(if_flush_i && (tag_owner_reg[gi-1] == OWNER_IF));
                        tag_owner_reg[gi] <= tag_owner_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Response steering from the last stage; a flush also hides a fetch
    // response that is arriving in the flush cycle itself.
    always_comb begin
        last_valid  = tag_valid_reg[LAST];
        last_owner  = tag_owner_reg[LAST];
        if_rvalid_o = last_valid && (last_owner == OWNER_IF) && !if_flush_i;
        dm_rvalid_o = last_valid && (last_owner == OWNER_DM);
        if_rdata_o  = if_rvalid_o ? ram_rd_data_i : '0;
        dm_rdata_o  = dm_rvalid_o ? ram_rd_data_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a random traffic
// run checked against a small arbitration/response model. A behavioural
// RAM with RD_LAT-cycle read latency sits on the RAM port.

module tb_mem_port_arbiter;

    localparam int XLEN       = 32;
    localparam int RD_LAT     = 3;
    localparam int STARVE_MAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_init;

    logic            if_req, if_flush, if_gnt, if_rvalid;
    logic [XLEN-1:0] if_addr, if_rdata;
    logic            dm_req, dm_wr_en, dm_gnt, dm_rvalid;
    logic [XLEN-1:0] dm_addr, dm_wr_data, dm_rdata;
    logic [3:0]      dm_byte_en;
    logic            ram_en;
    logic [XLEN-1:0] ram_addr, ram_wr_data, ram_rd_data;
    logic [3:0]      ram_wr_byte_en;

    int vectors    = 0;
    int miscompares = 0;

    mem_port_arbiter #(
        .XLEN(XLEN), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_addr_i(dm_addr), .dm_wr_en_i(dm_wr_en),
        .dm_wr_data_i(dm_wr_data), .dm_byte_en_i(dm_byte_en),
        .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_wr_byte_en_o(ram_wr_byte_en),
        .ram_wr_data_o(ram_wr_data), .ram_rd_data_i(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: word i initialises to 0xA5000000 | (byte address).
    logic [31:0] ram_mem [0:255];
    logic [31:0] rd_pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 32'hA500_0000 | (i << 2);
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wr_byte_en[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
        rd_pipe[0] <= ram_mem[ram_addr[9:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rd_data = rd_pipe[RD_LAT-1];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0; if_flush = 0;
        dm_req = 0; dm_addr = '0; dm_wr_en = 0; dm_wr_data = '0; dm_byte_en = '0;
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        rst = 1; mem_init = 1;
        idle_inputs();
        if_req = 1; dm_req = 1; if_addr = 32'h4; dm_addr = 32'h8;
        repeat (3) next_cycle();
        #1;
        vectors++;
        if ({if_gnt, dm_gnt, ram_en, if_rvalid, dm_rvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 00000", {if_gnt, dm_gnt, ram_en, if_rvalid, dm_rvalid});
        end
        vectors++;
        if ({ram_addr, ram_wr_data, ram_wr_byte_en, if_rdata, dm_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h wdata %h be %b ifr %h dmr %h required all 0",
                     ram_addr, ram_wr_data, ram_wr_byte_en, if_rdata, dm_rdata);
        end
        next_cycle();
        mem_init = 0; rst = 0;
        idle_inputs();
        next_cycle();
        $display("reset released");
    endtask

    // ---------------------------------------------------------------
    task automatic test_if_stream();
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if_req  = (c < 3);
            if_addr = (c < 3) ? 32'(4 * c) : '0;
            #1;
            vectors++;
            if (if_gnt !== (c < 3) || dm_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL if_stream_gnt c%0d: if_gnt %b dm_gnt %b required %b 0", c, if_gnt, dm_gnt, c < 3);
            end
            if (c < 3) begin
                vectors++;
                if (ram_en !== 1'b1 || ram_addr !== 32'(4 * c) || ram_wr_byte_en !== 4'b0) begin
                    miscompares++;
                    $display("FAIL if_stream_cmd c%0d: en %b addr %h be %b required 1 %h 0000",
                             c, ram_en, ram_addr, ram_wr_byte_en, 32'(4 * c));
                end
            end
            vectors++;
            if (if_rvalid !== (c >= 3) || dm_rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL if_stream_rvalid c%0d: if %b dm %b required %b 0", c, if_rvalid, dm_rvalid, c >= 3);
            end
            if (c >= 3) begin
                vectors++;
                if (if_rdata !== (32'hA500_0000 | 32'(4 * (c - 3)))) begin
                    miscompares++;
                    $display("FAIL if_stream_data c%0d: got %h required %h", c, if_rdata, 32'hA500_0000 | 32'(4 * (c - 3)));
                end
                $display("IF response %0d data %h", c - 3, if_rdata);
            end
        end
        idle_inputs();
    endtask

    // ---------------------------------------------------------------
    task automatic test_starvation();
        // Grant order with both requesting: DM x4, IF, DM x2.
        logic [6:0]  grant_if = 7'b0010000;
        logic [31:0] gaddr [7] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h80, 32'h50, 32'h54};
        int dm_k = 0;
        int if_k = 0;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if_req  = (c < 7);
            if_addr = 32'h80 + 32'(4 * if_k);
            dm_req  = (c < 7);
            dm_addr = 32'h40 + 32'(4 * dm_k);
            dm_wr_en = 0;
            #1;
            if (c < 7) begin
                vectors++;
                if (if_gnt !== grant_if[c] || dm_gnt !== !grant_if[c]) begin
                    miscompares++;
                    $display("FAIL starve_gnt c%0d: if %b dm %b required %b %b", c, if_gnt, dm_gnt, grant_if[c], !grant_if[c]);
                end
                vectors++;
                if (ram_addr !== gaddr[c]) begin
                    miscompares++;
                    $display("FAIL starve_addr c%0d: got %h required %h", c, ram_addr, gaddr[c]);
                end
                $display("grant c%0d %s addr %h", c, if_gnt ? "IF" : "DM", ram_addr);
            end
            if (c >= 3) begin
                vectors++;
                if (if_rvalid !== grant_if[c-3] || dm_rvalid !== !grant_if[c-3]) begin
                    miscompares++;
                    $display("FAIL starve_rvalid c%0d: if %b dm %b required %b %b", c, if_rvalid, dm_rvalid, grant_if[c-3], !grant_if[c-3]);
                end
                vectors++;
                if ((grant_if[c-3] ? if_rdata : dm_rdata) !== (32'hA500_0000 | gaddr[c-3])) begin
                    miscompares++;
                    $display("FAIL starve_data c%0d: if %h dm %h required %h", c, if_rdata, dm_rdata, 32'hA500_0000 | gaddr[c-3]);
                end
            end
            if (if_gnt) if_k++;
            if (dm_gnt) dm_k++;
        end
        idle_inputs();
    endtask

    // ---------------------------------------------------------------
    task automatic test_write();
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 0) begin
                dm_req = 1; dm_addr = 32'h100; dm_wr_en = 1;
                dm_wr_data = 32'hDEAD_BEEF; dm_byte_en = 4'b0011;
            end else if (c == 4) begin
                dm_req = 1; dm_addr = 32'h100; dm_wr_en = 0;
            end
            #1;
            if (c == 0) begin
                vectors++;
                if (dm_gnt !== 1'b1 || ram_en !== 1'b1 || ram_wr_byte_en !== 4'b0011 ||
                    ram_addr !== 32'h100 || ram_wr_data !== 32'hDEAD_BEEF) begin
                    miscompares++;
                    $display("FAIL write_cmd: gnt %b en %b be %b addr %h data %h required 1 1 0011 100 deadbeef",
                             dm_gnt, ram_en, ram_wr_byte_en, ram_addr, ram_wr_data);
                end
                $display("DM write 0x100 be 0011");
            end
            if (c == 4) begin
                vectors++;
                if (ram_wr_byte_en !== 4'b0000 || dm_gnt !== 1'b1) begin
                    miscompares++;
                    $display("FAIL read_cmd: gnt %b be %b required 1 0000", dm_gnt, ram_wr_byte_en);
                end
            end
            vectors++;
            if (dm_rvalid !== (c == 7)) begin
                miscompares++;
                $display("FAIL write_rvalid c%0d: got %b required %b", c, dm_rvalid, c == 7);
            end
            if (c == 7) begin
                vectors++;
                if (dm_rdata !== 32'hA500_BEEF) begin
                    miscompares++;
                    $display("FAIL write_readback: got %h required a500beef", dm_rdata);
                end
                $display("DM read 0x100 data %h", dm_rdata);
            end
        end
        idle_inputs();
    endtask

    // ---------------------------------------------------------------
    task automatic test_flush();
        logic [12:0] exp_if_gnt = 13'b0000100001011;  // c0, c1, c3, c8
        logic [12:0] exp_dm_gnt = 13'b0000000000100;  // c2
        logic [12:0] exp_if_rv  = 13'b0000001000000;  // c6 only
        logic [12:0] exp_dm_rv  = 13'b0000000100000;  // c5
        for (int c = 0; c < 13; c++) begin
            next_cycle();
            idle_inputs();
            case (c)
                0:  begin if_req = 1; if_addr = 32'h20; end
                1:  begin if_req = 1; if_addr = 32'h24; end
                2:  begin if_req = 1; if_addr = 32'h28; if_flush = 1; dm_req = 1; dm_addr = 32'h60; end
                3:  begin if_req = 1; if_addr = 32'h28; end
                8:  begin if_req = 1; if_addr = 32'h30; end
                11: if_flush = 1;
                default: ;
            endcase
            #1;
            vectors++;
            if (if_gnt !== exp_if_gnt[c] || dm_gnt !== exp_dm_gnt[c]) begin
                miscompares++;
                $display("FAIL flush_gnt c%0d: if %b dm %b required %b %b", c, if_gnt, dm_gnt, exp_if_gnt[c], exp_dm_gnt[c]);
            end
            vectors++;
            if (if_rvalid !== exp_if_rv[c] || dm_rvalid !== exp_dm_rv[c]) begin
                miscompares++;
                $display("FAIL flush_rvalid c%0d: if %b dm %b required %b %b", c, if_rvalid, dm_rvalid, exp_if_rv[c], exp_dm_rv[c]);
            end
            if (c == 5) begin
                vectors++;
                if (dm_rdata !== 32'hA500_0060) begin
                    miscompares++;
                    $display("FAIL flush_dm_data: got %h required a5000060", dm_rdata);
                end
            end
            if (c == 6) begin
                vectors++;
                if (if_rdata !== 32'hA500_0028) begin
                    miscompares++;
                    $display("FAIL flush_if_data: got %h required a5000028", if_rdata);
                end
            end
            if (c == 11) begin
                vectors++;
                if (if_rdata !== 32'h0) begin
                    miscompares++;
                    $display("FAIL flush_last_data: got %h required 0", if_rdata);
                end
            end
        end
        $display("flush scenario done");
        idle_inputs();
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset_midflight();
        int dm_k = 0;
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            idle_inputs();
            if (c <= 5) begin
                if_req = 1; if_addr = 32'h200;
                dm_req = 1; dm_addr = 32'h10 + 32'(4 * dm_k);
            end
            rst = (c == 4);
            #1;
            if (c < 4 || c == 5) begin
                vectors++;
                if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midreset_gnt c%0d: if %b dm %b required 0 1", c, if_gnt, dm_gnt);
                end
            end
            if (c == 4) begin
                vectors++;
                if ({if_gnt, dm_gnt, ram_en, if_rvalid, dm_rvalid, ram_addr, ram_wr_byte_en, if_rdata, dm_rdata} !== '0) begin
                    miscompares++;
                    $display("FAIL midreset_outputs: gnt %b%b en %b rv %b%b addr %h required all 0",
                             if_gnt, dm_gnt, ram_en, if_rvalid, dm_rvalid, ram_addr);
                end
                $display("reset pulse with reads in flight");
            end
            if (c >= 4) begin
                vectors++;
                if (if_rvalid !== 1'b0 || dm_rvalid !== (c == 8)) begin
                    miscompares++;
                    $display("FAIL midreset_rvalid c%0d: if %b dm %b required 0 %b", c, if_rvalid, dm_rvalid, c == 8);
                end
            end
            if (c == 8) begin
                vectors++;
                if (dm_rdata !== 32'hA500_0020) begin
                    miscompares++;
                    $display("FAIL midreset_data: got %h required a5000020", dm_rdata);
                end
            end
            if (dm_gnt) dm_k++;
        end
        idle_inputs();
        repeat (4) next_cycle();
    endtask

    // ---------------------------------------------------------------
    task automatic test_random();
        int          starve_m = 0;
        bit          ev [8];
        bit          eo [8];
        logic [31:0] ed [8];
        bit          if_pend = 0;
        bit          dm_pend = 0;
        bit          cand, win, exp_if, exp_dm;
        logic [31:0] exp_ifd, exp_dmd;
        logic [3:0]  exp_be;
        int          slot, ns;
        for (int i = 0; i < 8; i++) begin ev[i] = 0; eo[i] = 0; ed[i] = '0; end
        for (int cyc = 0; cyc < 2000 + RD_LAT + 1; cyc++) begin
            next_cycle();
            if (cyc < 2000) begin
                if (!if_pend && $urandom_range(0, 1) == 1) begin
                    if_pend = 1; if_addr = 32'($urandom_range(0, 63)) << 2;
                end
                if (!dm_pend && $urandom_range(0, 2) != 0) begin
                    dm_pend    = 1;
                    dm_addr    = 32'($urandom_range(0, 63)) << 2;
                    dm_wr_en   = ($urandom_range(0, 2) == 0);
                    dm_wr_data = $urandom;
                    dm_byte_en = 4'($urandom_range(1, 15));
                end
                if_flush = ($urandom_range(0, 7) == 0);
            end else begin
                if_flush = 0;
            end
            if_req = if_pend;
            dm_req = dm_pend;
            #1;
            cand   = if_req && !if_flush;
            win    = cand && (starve_m == STARVE_MAX);
            exp_dm = dm_req && !win;
            exp_if = cand && !exp_dm;
            exp_be = (exp_dm && dm_wr_en) ? dm_byte_en : 4'b0;
            vectors++;
            if (if_gnt !== exp_if || dm_gnt !== exp_dm || ram_en !== (exp_if || exp_dm) || ram_wr_byte_en !== exp_be) begin
                miscompares++;
                $display("FAIL rand_gnt cyc%0d: if %b dm %b en %b be %b required %b %b %b %b",
                         cyc, if_gnt, dm_gnt, ram_en, ram_wr_byte_en, exp_if, exp_dm, exp_if || exp_dm, exp_be);
            end
            vectors++;
            if (if_gnt && dm_gnt) begin
                miscompares++;
                $display("FAIL rand_exclusive cyc%0d: both gnts high, required at most one", cyc);
            end
            if (if_flush)
                for (int i = 0; i < 8; i++) if (!eo[i]) ev[i] = 0;
            slot    = cyc % 8;
            exp_ifd = (ev[slot] && !eo[slot]) ? ed[slot] : 32'h0;
            exp_dmd = (ev[slot] &&  eo[slot]) ? ed[slot] : 32'h0;
            vectors++;
            if (if_rvalid !== (ev[slot] && !eo[slot]) || dm_rvalid !== (ev[slot] && eo[slot]) ||
                if_rdata !== exp_ifd || dm_rdata !== exp_dmd) begin
                miscompares++;
                $display("FAIL rand_resp cyc%0d: rv %b%b data %h %h required %b%b %h %h", cyc,
                         if_rvalid, dm_rvalid, if_rdata, dm_rdata,
                         ev[slot] && !eo[slot], ev[slot] && eo[slot], exp_ifd, exp_dmd);
            end
            ev[slot] = 0;
            ns = (cyc + RD_LAT) % 8;
            if (exp_if) begin
                ev[ns] = 1; eo[ns] = 0; ed[ns] = ram_mem[if_addr[9:2]];
            end else if (exp_dm && !dm_wr_en) begin
                ev[ns] = 1; eo[ns] = 1; ed[ns] = ram_mem[dm_addr[9:2]];
            end
            if (exp_if || !cand) starve_m = 0;
            else if (exp_dm && starve_m < STARVE_MAX) starve_m++;
            if (if_gnt) if_pend = 0;
            if (dm_gnt) dm_pend = 0;
        end
        idle_inputs();
        $display("random traffic done");
    endtask

    initial begin
        test_reset();
        test_if_stream();
        test_starvation();
        test_write();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified RAM between the instruction-fetch requester (IF) and the load/store requester (DM) of the hxd32 core.
- Arbitrates one RAM command per cycle, with back-to-back issue.
- Tracks in-flight reads through a RD_LAT-deep owner-tag pipeline and routes each read response to its owner.
- Supports a fetch flush that squashes in-flight fetch responses on redirect.

Parameters:
- XLEN, 32, data/address width.
- RD_LAT, 1, cycles from RAM command to ram_rd_data_i valid; legal 1..4.
- STARVE_MAX, 4, max consecutive DM grants while IF is waiting; legal 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- if_req_i  in  1  fetch request.
- if_addr_i  in  XLEN  fetch byte address.
- if_flush_i  in  1  squash in-flight fetch responses; block IF grant this cycle.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch response valid.
- if_rdata_o  out  XLEN  fetch response data.
- dm_req_i  in  1  data request.
- dm_addr_i  in  XLEN  data byte address.
- dm_wr_en_i  in  1  1 = write, 0 = read.
- dm_wr_data_i  in  XLEN  write data.
- dm_byte_en_i  in  4  write byte enables.
- dm_gnt_o  out  1  data request accepted this cycle.
- dm_rvalid_o  out  1  load response valid.
- dm_rdata_o  out  XLEN  load response data.
- ram_en_o  out  1  RAM command valid.
- ram_addr_o  out  XLEN  RAM address.
- ram_wr_byte_en_o  out  4  RAM byte write enables; 0 = read.
- ram_wr_data_o  out  XLEN  RAM write data.
- ram_rd_data_i  in  XLEN  RAM read data, RD_LAT cycles after command.

Behaviour:
- Handshake:
  - Requesters hold req and all payload stable until they see gnt high.
  - A request is accepted in a cycle where req and gnt are both high.
  - gnt is combinational from req within the same cycle.
  - At most one of if_gnt_o and dm_gnt_o is high in any cycle.
- Arbitration:
  - DM has priority by default.
  - IF wins when starve_cnt == STARVE_MAX and if_req_i is high and if_flush_i is low.
  - The IF candidate is if_req_i && !if_flush_i.
- starve_cnt (4-bit register):
  - Increments when dm_gnt_o is high and the IF candidate is high.
  - Clears when if_gnt_o is high or the IF candidate is low.
  - Saturates at STARVE_MAX.
- RAM command (combinational from the granted requester, same cycle):
  - ram_en_o = if_gnt_o | dm_gnt_o.
  - IF grant: ram_wr_byte_en_o = 0.
  - DM read: ram_wr_byte_en_o = 0.
  - DM write: ram_wr_byte_en_o = dm_byte_en_i.
  - When no grant: ram_addr_o, ram_wr_data_o and ram_wr_byte_en_o are 0.
- Tag pipeline:
  - RD_LAT stages, each holding {valid, owner}.
  - Stage 0 is loaded on every grant that is a read (IF, or DM with wr_en = 0).
  - Writes load valid = 0; writes produce no response.
  - Stages shift every cycle.
- Responses:
  - if_rvalid_o = last-stage valid && owner == IF.
  - dm_rvalid_o = last-stage valid && owner == DM.
  - Response arrives exactly RD_LAT cycles after the grant.
  - rdata_o = ram_rd_data_i when the matching rvalid is high, else 0.
- Flush:
  - A cycle with if_flush_i high clears valid on every IF-owned stage at the clock edge.
  - The last stage is also squashed combinationally, so if_rvalid_o is 0 in the flush cycle.
  - DM entries are unaffected.
- Simultaneous events:
  - Both requesting with starve_cnt < STARVE_MAX: DM granted, IF waits.
  - Flush with if_req_i high: no IF grant; DM may be granted.
- Reset:
  - All tag stages invalid, starve_cnt = 0.
  - All outputs 0, including gnts (which are also forced 0 while rst_i is high).
  - Reset mid-operation discards all in-flight responses; no rvalid appears after reset for commands issued before it.

Test Plan:
- RD_LAT=1, IF-only, reads 0x0, 0x4, 0x8 back-to-back:
  - if_gnt_o high 3 cycles.
  - if_rvalid_o high cycles 1-3 with RAM words for 0x0, 0x4, 0x8.
  - dm_rvalid_o stays 0.
- Both requesting, STARVE_MAX=4, DM continuous reads:
  - Grants DM,DM,DM,DM,IF,DM...
  - starve_cnt 1,2,3,4,0.
  - Responses return in grant order to the correct owner.
- DM write 0xDEADBEEF to 0x100 with byte_en 0b0011:
  - ram_wr_byte_en_o = 0b0011 in the grant cycle.
  - No dm_rvalid_o.
  - A later read of 0x100 returns 0x????BEEF with the upper half unchanged.
- RD_LAT=3, IF reads at 0x20/0x24, then flush the next cycle with DM read pending:
  - No if_rvalid_o for either fetch.
  - dm_rvalid_o arrives 3 cycles after its grant.
- Assert rst_i for 1 cycle while 2 reads are in flight (RD_LAT=2):
  - All outputs 0 during reset.
  - No rvalid afterwards.
  - starve_cnt = 0, so the next both-request cycle grants DM.
- Random IF/DM/flush traffic, 2000 cycles:
  - Never both gnts high.
  - Every unflushed read gets exactly one rvalid at grant + RD_LAT with scoreboard-matching data.
